// File: rtl/frame_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_arb_pkg
// Description : Shared definitions for the frame stream arbiter: arbiter
//               state encoding, channel-index width helper, beat counter
//               width helper and m_axis_tuser field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_arb_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DRAIN = 2'd2,
    S_ABORT = 2'd3
  } arb_state_e;

  // Channel index width; a single-bit index is kept even for two channels
  function automatic int ch_w(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  // Beat counter must hold MAX_FRAME_LEN itself without wrapping
  function automatic int beat_cnt_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  // m_axis_tuser layout: {err, source_channel}
  localparam int TUSER_CH_LSB = 0;

  function automatic int tuser_err_idx(input int num_ch);
    return ch_w(num_ch);
  endfunction

endpackage : frame_arb_pkg
`default_nettype wire

// File: rtl/frame_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : frame_rr_picker
// Description : Combinational round-robin selector. Starting from the
//               channel after last_grant_i, returns the first requesting
//               channel.
// Ports       : req_i        [NUM_CH-1:0] request vector
//               last_grant_i [CH_W-1:0]   channel granted most recently
//               grant_o      [CH_W-1:0]   selected channel (valid if any_req_o)
//               any_req_o                 at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rr_picker
  import frame_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_grant_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_req_o
);

  int w_idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last_grant_i is the final (winning) assignment.
  always_comb begin
    grant_o   = last_grant_i;
    any_req_o = |req_i;
    w_idx     = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = (int'(last_grant_i) + k) % NUM_CH;
      if (req_i[w_idx]) begin
        grant_o = CH_W'(w_idx);
      end
    end
  end

endmodule : frame_rr_picker
`default_nettype wire

// File: rtl/frame_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_stream_arbiter
// Description : Frame-granular round-robin merge of NUM_CH byte streams into
//               a single registered AXI-Stream output. Oversize frames are
//               truncated with an error beat and the remainder drained.
//               Optional mid-frame stall timeout is compiled in with the
//               macro FRAME_ARB_TIMEOUT_EN (abort beat 8'h00, tlast, err).
// Ports       : core_clk, rst_n (async, active-low)
//               s_axis_tdata  [NUM_CH*8-1:0] per-channel bytes
//               s_axis_tvalid/s_axis_tlast [NUM_CH-1:0], s_axis_tready out
//               m_axis_tdata [7:0], m_axis_tvalid, m_axis_tlast,
//               m_axis_tuser [CH_W:0] = {err, source}, m_axis_tready in
//               frame_start_o  pulse when a grant is issued
//               frame_err_o    pulse when an err beat leaves the output
// Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_arbiter
  import frame_arb_pkg::*;
#(
  parameter  int NUM_CH         = 2,
  parameter  int MAX_FRAME_LEN  = 256,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CH_W           = ch_w(NUM_CH)
) (
  input  logic                core_clk,
  input  logic                rst_n,
  input  logic [NUM_CH*8-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]   s_axis_tvalid,
  input  logic [NUM_CH-1:0]   s_axis_tlast,
  output logic [NUM_CH-1:0]   s_axis_tready,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  output logic [CH_W:0]       m_axis_tuser,
  input  logic                m_axis_tready,
  output logic                frame_start_o,
  output logic                frame_err_o
);

  localparam int BCW     = beat_cnt_w(MAX_FRAME_LEN);
  localparam int ERR_IDX = tuser_err_idx(NUM_CH);

  // Elaboration-time parameter range checks
  generate
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("frame_stream_arbiter: NUM_CH must be in 2..8");
    end
    if (MAX_FRAME_LEN < 2) begin : g_bad_max_len
      $error("frame_stream_arbiter: MAX_FRAME_LEN must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("frame_stream_arbiter: TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  arb_state_e       state_q;
  logic [CH_W-1:0]  grant_q;
  logic [CH_W-1:0]  last_grant_q;
  logic [BCW-1:0]   beat_cnt_q;
  logic [7:0]       m_data_q;
  logic             m_last_q;
  logic [CH_W:0]    m_user_q;
  logic             m_valid_q;
  logic             start_q;

`ifdef FRAME_ARB_TIMEOUT_EN
  localparam int STW = $clog2(TIMEOUT_CYCLES + 1);
  logic [STW-1:0]   stall_q;
`endif

  logic [CH_W-1:0]  w_pick;
  logic             w_any_req;
  logic [7:0]       w_in_data;
  logic             w_in_valid;
  logic             w_in_last;
  logic             w_out_free;
  logic             w_accept;
  logic             w_at_max;

  frame_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i        (s_axis_tvalid),
    .last_grant_i (last_grant_q),
    .grant_o      (w_pick),
    .any_req_o    (w_any_req)
  );

  // Output slot can take a beat this cycle
  assign w_out_free = !m_valid_q || m_axis_tready;

  // Granted channel's input mux and per-channel ready
  always_comb begin
    w_in_data     = 8'h00;
    w_in_valid    = 1'b0;
    w_in_last     = 1'b0;
    s_axis_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == CH_W'(c)) begin
        w_in_data  = s_axis_tdata[c*8 +: 8];
        w_in_valid = s_axis_tvalid[c];
        w_in_last  = s_axis_tlast[c];
        if (state_q == S_FRAME) begin
          s_axis_tready[c] = w_out_free;
        end else if (state_q == S_DRAIN) begin
          s_axis_tready[c] = 1'b1;
        end
      end
    end
  end

  assign w_accept = w_in_valid && (|(s_axis_tready & s_axis_tvalid));
  // The beat being accepted now is the MAX_FRAME_LEN-th of the frame
  assign w_at_max = (beat_cnt_q == BCW'(MAX_FRAME_LEN - 1));

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      beat_cnt_q   <= '0;
      m_data_q     <= 8'h00;
      m_last_q     <= 1'b0;
      m_user_q     <= '0;
      m_valid_q    <= 1'b0;
      start_q      <= 1'b0;
`ifdef FRAME_ARB_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      // Downstream took the held beat; any new load below overrides this
      if (m_valid_q && m_axis_tready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (w_any_req) begin
            grant_q    <= w_pick;
            start_q    <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= S_FRAME;
`ifdef FRAME_ARB_TIMEOUT_EN
            stall_q    <= '0;
`endif
          end
        end

        S_FRAME: begin
`ifdef FRAME_ARB_TIMEOUT_EN
          if (w_in_valid) begin
            stall_q <= '0;
          end else if (stall_q == STW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_ABORT;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
          if (w_accept) begin
            m_valid_q  <= 1'b1;
            m_data_q   <= w_in_data;
            // Truncate an oversize frame: forced tlast plus err flag
            m_last_q   <= w_in_last || w_at_max;
            m_user_q   <= {(!w_in_last && w_at_max), grant_q};
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (w_in_last) begin
              last_grant_q <= grant_q;
              state_q      <= S_IDLE;
            end else if (w_at_max) begin
              state_q <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (w_accept && w_in_last) begin
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
          end
        end

        S_ABORT: begin
`ifdef FRAME_ARB_TIMEOUT_EN
          if (w_out_free) begin
            m_valid_q <= 1'b1;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b1;
            m_user_q  <= {1'b1, grant_q};
            state_q   <= S_DRAIN;
          end
`else
          state_q <= S_IDLE;
`endif
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = {m_user_q[ERR_IDX], m_user_q[TUSER_CH_LSB +: CH_W]};
  assign frame_start_o = start_q;
  assign frame_err_o   = m_valid_q && m_axis_tready && m_user_q[ERR_IDX];

endmodule : frame_stream_arbiter
`default_nettype wire

// File: tb/tb_frame_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_stream_arbiter
// Description : Self-checking bench for frame_stream_arbiter (NUM_CH=2,
//               MAX_FRAME_LEN=8, TIMEOUT_CYCLES=16). A frame-level model
//               predicts the merged output beat stream; a compare process
//               checks every output handshake and hold stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_stream_arbiter;

  localparam int NUM_CH  = 2;
  localparam int MAX_LEN = 8;
  localparam int TMO     = 16;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } in_beat_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
    int         ch;
  } out_beat_t;

  logic                core_clk = 1'b0;
  logic                rst_n    = 1'b0;
  logic [NUM_CH*8-1:0] s_axis_tdata  = '0;
  logic [NUM_CH-1:0]   s_axis_tvalid = '0;
  logic [NUM_CH-1:0]   s_axis_tlast  = '0;
  logic [NUM_CH-1:0]   s_axis_tready;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tlast;
  logic [1:0]          m_axis_tuser;
  logic                m_axis_tready = 1'b0;
  logic                frame_start_o;
  logic                frame_err_o;

  frame_stream_arbiter #(
    .NUM_CH         (NUM_CH),
    .MAX_FRAME_LEN  (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .core_clk      (core_clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .frame_start_o (frame_start_o),
    .frame_err_o   (frame_err_o)
  );

  always #5 core_clk = ~core_clk;

  in_beat_t  in_q [NUM_CH][$];
  out_beat_t exp_q[$];
  int        hs_log[$];
  int        n_vec = 0;
  int        n_err = 0;
  int        cyc = 0;
  int        starts = 0;
  int        errs = 0;
  int        rdy_mode = 0;
  int        m_last_grant = NUM_CH - 1;
  logic      hold_prev = 1'b0;
  logic [11:0] prev_bus = '0;
  out_beat_t ce;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin: first requester after 'last'
  function automatic int rr_next(input int last, input logic [NUM_CH-1:0] req);
    int i;
    for (int k = 1; k <= NUM_CH; k++) begin
      i = (last + k) % NUM_CH;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // Queue one input frame and the output beats it must produce
  task automatic model_frame(input int ch, input int n, input logic [7:0] base,
                             input int gap_at, input int gap_len, input int abort_after);
    in_beat_t  ib;
    out_beat_t ob;
    for (int i = 0; i < n; i++) begin
      ib.d   = base + 8'(i);
      ib.l   = (i == n - 1);
      ib.gap = (i == gap_at) ? gap_len : 0;
      in_q[ch].push_back(ib);
    end
    if (abort_after > 0) begin
      for (int i = 0; i < abort_after; i++) begin
        ob.d = base + 8'(i); ob.l = 1'b0; ob.e = 1'b0; ob.ch = ch;
        exp_q.push_back(ob);
      end
      ob.d = 8'h00; ob.l = 1'b1; ob.e = 1'b1; ob.ch = ch;
      exp_q.push_back(ob);
    end else begin
      for (int i = 0; i < ((n < MAX_LEN) ? n : MAX_LEN); i++) begin
        ob.d  = base + 8'(i);
        ob.ch = ch;
        if (n <= MAX_LEN) begin
          ob.l = (i == n - 1); ob.e = 1'b0;
        end else begin
          ob.l = (i == MAX_LEN - 1); ob.e = (i == MAX_LEN - 1);
        end
        exp_q.push_back(ob);
      end
    end
    m_last_grant = ch;
  endtask

  function automatic bit busy();
    return (exp_q.size() != 0) || (in_q[0].size() != 0) || (in_q[1].size() != 0);
  endfunction

  // One clock of stimulus: drive at negedge, retire accepted input beats
  task automatic step();
    in_beat_t b;
    @(negedge core_clk);
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      s_axis_tvalid[c]      = 1'b0;
      s_axis_tlast[c]       = 1'b0;
      s_axis_tdata[c*8 +: 8] = 8'h00;
      if (in_q[c].size() > 0) begin
        b = in_q[c][0];
        if (b.gap > 0) begin
          b.gap--;
          in_q[c][0] = b;
        end else begin
          s_axis_tvalid[c]      = 1'b1;
          s_axis_tlast[c]       = b.l;
          s_axis_tdata[c*8 +: 8] = b.d;
        end
      end
    end
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 1);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_axis_tvalid[c] && s_axis_tready[c]) void'(in_q[c].pop_front());
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    if (busy()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: %0d beats still expected, required 0", name, exp_q.size());
    end
    repeat (3) step();
  endtask

  // Compare process: every output handshake against the model
  always @(negedge core_clk) begin
    #2;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_start_o) starts++;
      if (frame_err_o) errs++;
      if (hold_prev)
        chk("hold_stable", longint'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
            longint'({1'b1, prev_bus[10:0]}));
      if (m_axis_tvalid && m_axis_tready) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h tlast %0b tuser %0h, expected no beat",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          ce = exp_q.pop_front();
          chk("out_data", longint'(m_axis_tdata), longint'(ce.d));
          chk("out_last", longint'(m_axis_tlast), longint'(ce.l));
          chk("out_user", longint'(m_axis_tuser), longint'(ce.e) * 2 + longint'(ce.ch));
          chk("err_pulse", longint'(frame_err_o), longint'(ce.e));
        end
      end else begin
        chk("err_idle", longint'(frame_err_o), 0);
      end
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_bus  = {1'b0, m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, o0;
    repeat (3) @(negedge core_clk);
    #1;
    chk("rst_m_valid", longint'(m_axis_tvalid), 0);
    chk("rst_outputs", longint'({m_axis_tdata, m_axis_tlast, m_axis_tuser, frame_start_o, frame_err_o}), 0);
    chk("rst_tready", longint'(s_axis_tready), 0);
    rst_n = 1'b1;

    // Two simultaneous 4-beat frames: ch0 first, one bubble, then ch1
    chk("rr_first_after_reset", rr_next(m_last_grant, 2'b11), 0);
    s0 = starts;
    hs_log.delete();
    o0 = rr_next(m_last_grant, 2'b11);
    model_frame(o0, 4, 8'h10 + 8'(o0 * 16), -1, 0, 0);
    o0 = rr_next(m_last_grant, 2'b11);
    model_frame(o0, 4, 8'h10 + 8'(o0 * 16), -1, 0, 0);
    chk("model_s1_len", exp_q.size(), 8);
    chk("model_s1_second_ch", exp_q[4].ch, 1);
    wait_done("s1", 100);
    chk("s1_starts", starts - s0, 2);
    if (hs_log.size() >= 5) chk("s1_bubble", hs_log[4] - hs_log[3], 2);
    else chk("s1_hs_count", hs_log.size(), 8);

    // Output back-pressure toggling every cycle
    s0 = starts;
    rdy_mode = 1;
    model_frame(1, 6, 8'h30, -1, 0, 0);
    wait_done("s2", 100);
    rdy_mode = 0;
    chk("s2_starts", starts - s0, 1);

    // Oversize frame: 12 beats, truncated at 8 with err, rest drained
    e0 = errs;
    model_frame(0, 12, 8'h40, -1, 0, 0);
    chk("model_s3_len", exp_q.size(), 8);
    chk("model_s3_err_beat", longint'({exp_q[7].l, exp_q[7].e}), 3);
    wait_done("s3", 100);
    chk("s3_err_pulses", errs - e0, 1);

    // Exactly MAX_LEN beats: normal frame, then a following frame passes
    e0 = errs;
    model_frame(0, 8, 8'h50, -1, 0, 0);
    chk("model_s4_last", longint'({exp_q[7].l, exp_q[7].e}), 2);
    model_frame(0, 2, 8'h5A, -1, 0, 0);
    wait_done("s4", 100);
    chk("s4_err_pulses", errs - e0, 0);

    // Mid-frame input stall of 20 cycles after 3 beats
    e0 = errs;
`ifdef FRAME_ARB_TIMEOUT_EN
    model_frame(0, 5, 8'h70, 3, 20, 3);
    chk("model_s5_abort_data", longint'(exp_q[3].d), 0);
    model_frame(0, 2, 8'h78, -1, 0, 0);
    wait_done("s5", 150);
    chk("s5_err_pulses", errs - e0, 1);
`else
    model_frame(0, 5, 8'h70, 3, 20, 0);
    wait_done("s5", 150);
    chk("s5_err_pulses", errs - e0, 0);
`endif

    // Reset in the middle of a ch1 frame
    model_frame(1, 6, 8'h60, -1, 0, 0);
    repeat (4) step();
    @(negedge core_clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    in_q[0].delete();
    in_q[1].delete();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    #1;
    chk("midrst_m_valid", longint'(m_axis_tvalid), 0);
    chk("midrst_outputs", longint'({m_axis_tdata, m_axis_tlast, m_axis_tuser, frame_start_o, frame_err_o}), 0);
    chk("midrst_tready", longint'(s_axis_tready), 0);
    repeat (2) step();
    @(negedge core_clk);
    #3;
    rst_n = 1'b1;
    m_last_grant = NUM_CH - 1;
    s0 = starts;
    o0 = rr_next(m_last_grant, 2'b11);
    chk("rr_after_midrst", o0, 0);
    model_frame(o0, 3, 8'h80 + 8'(o0 * 16), -1, 0, 0);
    o0 = rr_next(m_last_grant, 2'b11);
    model_frame(o0, 3, 8'h80 + 8'(o0 * 16), -1, 0, 0);
    wait_done("s6", 100);
    chk("s6_starts", starts - s0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_frame_stream_arbiter
`default_nettype wire

// File: doc/frame_stream_arbiter.md
FRAME_STREAM_ARBITER -- requirements
Module: frame_stream_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of byte-stream requesters (frame-synced detector outputs), range 2..8.
REQ-002 Parameter MAX_FRAME_LEN, default 256, maximum beats per frame (255 payload + 1 pad).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, mid-frame input-stall limit (used only when the timeout feature is compiled in).
REQ-004 core_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 s_axis_tdata  in  NUM_CH*8  per-channel byte; channel i occupies bits [i*8+7:i*8].
REQ-007 s_axis_tvalid / s_axis_tlast  in  NUM_CH  per-channel valid / end-of-frame.
REQ-008 s_axis_tready  out  NUM_CH  per-channel ready.
REQ-009 m_axis_tdata  out  8  merged output byte.
REQ-010 m_axis_tvalid / m_axis_tlast  out  1  merged output valid / end-of-frame.
REQ-011 m_axis_tuser  out  CH_W+1  [CH_W-1:0] is the source channel; [CH_W] is the frame-error flag; CH_W = max(1, clog2(NUM_CH)).
REQ-012 m_axis_tready  in  1  downstream ready.
REQ-013 frame_start_o  out  1  one-cycle pulse when a grant is issued.
REQ-014 frame_err_o  out  1  one-cycle pulse when an error beat is accepted downstream.

Function
REQ-015 Arbitration is frame-granular: a grant holds until its tlast beat, or until an abort, is handed to the output register.
REQ-016 State machine states are S_IDLE, S_FRAME, S_DRAIN and S_ABORT; reset state is S_IDLE.
- S_IDLE: when any s_axis_tvalid is high, grant the first requesting channel after last_grant in round-robin order.
- S_IDLE also pulses frame_start_o, clears beat_cnt and moves to S_FRAME; one bubble cycle per frame.
REQ-017 In S_FRAME, s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready); every other tready is 0.
REQ-018 Output is a single register stage: an accepted input beat appears on m_axis_* the next cycle.
- m_axis_tdata, tlast and tuser stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 An accepted beat with tlast=1 in S_FRAME sets last_grant <= grant and returns to S_IDLE.
REQ-020 Oversize handling: beat_cnt counts accepted beats; beat MAX_FRAME_LEN accepted without tlast is output with tlast=1 and err=1.
- The block then enters S_DRAIN.
REQ-021 S_DRAIN: tready[grant] = 1; input beats are discarded until a beat with tlast is accepted, then S_IDLE.
REQ-022 A tlast arriving on exactly the MAX_FRAME_LEN-th beat is a normal frame: err=0, no drain.
REQ-023 frame_err_o pulses in the cycle an err=1 beat completes the m_axis handshake.
REQ-024 beat_cnt width is clog2(MAX_FRAME_LEN)+1; it never wraps within a frame.

Reset
REQ-025 While rst_n=0:
- all outputs are 0; state = S_IDLE; beat_cnt = 0;
- last_grant = NUM_CH-1, so channel 0 wins the first arbitration.
REQ-026 Reset mid-frame drops the frame; no tlast or error beat is emitted afterward.

Configuration
REQ-027 Macro FRAME_ARB_TIMEOUT_EN:
- Defined: in S_FRAME a stall counter increments each cycle s_axis_tvalid[grant]=0 and clears on any grant valid.
- On reaching TIMEOUT_CYCLES the block enters S_ABORT.
- S_ABORT emits one beat: data 8'h00, tlast=1, err=1, source = grant. It waits for the output slot, then goes to S_DRAIN.
- Undefined: there is no stall counter and no S_ABORT path; a stalled grant is held indefinitely.

Structure
REQ-028 Package frame_arb_pkg holds the state encoding, the CH_W function and the tuser field index constants.
REQ-029 Sub-module frame_rr_picker implements the combinational round-robin selection: request vector + last_grant -> grant index + any_req.

Verification
REQ-030 Ch0 and ch1 each send one 4-beat frame at the same cycle.
- Required: ch0 frame (tuser=0), then ch1 frame (tuser=1), one bubble between them, two frame_start_o pulses.
REQ-031 Ch1 sends a frame with m_axis_tready toggling 1/0 every cycle.
- Required: the output sequence is byte-identical to the input; tdata is stable during stalls.
REQ-032 MAX_FRAME_LEN=8, ch0 sends 12 beats, tlast on beat 12.
- Required: 8 output beats, 8th has tlast=1 and err=1; frame_err_o pulses once; beats 9..12 are discarded.
REQ-033 MAX_FRAME_LEN=8, ch0 sends exactly 8 beats, tlast on beat 8.
- Required: normal frame, err=0, no drain.
REQ-034 FRAME_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16; ch0 stalls for 16 cycles after 3 beats.
- Required: 4th output beat is 8'h00 with tlast=1 and err=1; the block drains to the next ch0 tlast.
REQ-035 rst_n asserted in mid-frame.
- Required: all outputs are 0 immediately; after release, ch0 wins arbitration first.
